// File: rtl/pcie_ss_cpl_gen_pkg.sv
// Shared types and helpers for the PCIe SS AXI-S completion generator.
// Header layout follows the PCIe 3DW completion format, DW0 in bits [31:0].
package pcie_ss_cpl_gen_pkg;

  localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;
  localparam logic [2:0] CPL_STATUS_SC = 3'b000;

  typedef struct packed {
    logic [31:0] rsvd_dw3;
    // DW2
    logic [15:0] req_id;
    logic [7:0]  tag_lo;
    logic        rsvd_dw2;
    logic [6:0]  lower_addr;
    // DW1
    logic [15:0] cpl_id;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byte_count;
    // DW0
    logic [7:0]  fmt_type;
    logic        tag9;
    logic [2:0]  tc;
    logic        tag8;
    logic        attr2;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [9:0]  length;
  } t_cpl_hdr;

  typedef struct packed {
    logic [9:0]  tag;
    logic [15:0] rid;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [11:0] addr;
    logic [9:0]  len_dw;
  } t_cpl_req;

  // Low-byte mask covering 'bytes' bytes; zero means a full beat.
  function automatic logic [127:0] cpl_tkeep(input logic [12:0] bytes);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++) begin
      m[i] = (bytes == 13'd0) || (13'(i) < bytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_cpl_gen_oreg.sv
// Single-stage TX output register; holds its contents while stalled and
// clears side-band fields when the beat drains.
module pcie_ss_axis_cpl_gen_oreg
  import pcie_ss_cpl_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_keep,
  input  logic                    i_last,
  input  logic                    i_sop,
  input  t_cpl_hdr                i_hdr,
  input  logic                    o_tready,
  output logic                    o_tvalid,
  output logic [DATA_WIDTH-1:0]   o_tdata,
  output logic [DATA_WIDTH/8-1:0] o_tkeep,
  output logic                    o_tlast,
  output logic                    o_tuser_sop,
  output logic [127:0]            o_tuser_hdr
);

  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH/8-1:0] r_keep;
  logic                    r_last;
  logic                    r_sop;
  t_cpl_hdr                r_hdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_sop   <= 1'b0;
      r_hdr   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
      r_sop   <= i_sop;
      r_hdr   <= i_hdr;
    end else if (o_tready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_sop   <= 1'b0;
      r_hdr   <= '0;
    end
  end

  assign o_tvalid    = r_valid;
  assign o_tdata     = r_data;
  assign o_tkeep     = r_keep;
  assign o_tlast     = r_last;
  assign o_tuser_sop = r_sop;
  assign o_tuser_hdr = r_hdr;

endmodule

// File: rtl/pcie_ss_axis_cpl_gen.sv
// TX-side completer: turns one memory read descriptor plus its payload beats
// into CplD TLPs split at MAX_CPL_BYTES, header carried on the SOP beat.
module pcie_ss_axis_cpl_gen
  import pcie_ss_cpl_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned MAX_CPL_BYTES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             cpl_id,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [9:0]              req_tag,
  input  logic [15:0]             req_rid,
  input  logic [2:0]              req_tc,
  input  logic [2:0]              req_attr,
  input  logic [11:0]             req_addr,
  input  logic [9:0]              req_len_dw,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  input  logic [DATA_WIDTH-1:0]   i_tdata,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic [DATA_WIDTH-1:0]   o_tdata,
  output logic [DATA_WIDTH/8-1:0] o_tkeep,
  output logic                    o_tlast,
  output logic [127:0]            o_tuser_hdr,
  output logic                    o_tuser_sop,
  output logic                    busy
);

  localparam int unsigned BeatBytes = DATA_WIDTH / 8;
  localparam int unsigned BeatShift = $clog2(BeatBytes);

  typedef enum logic [1:0] {StIdle, StChunk, StXfer} t_state;

  t_state      r_state, w_state_d;
  t_cpl_req    r_req, w_req_d, w_req_in;
  logic [12:0] r_sent, w_sent_d;
  logic [12:0] r_chunk, w_chunk_d;
  logic [12:0] r_beats, w_beats_d;
  logic        r_first, w_first_d;
  t_cpl_hdr    r_hdr, w_hdr_d;

  logic [12:0]           w_total;
  logic [12:0]           w_left;
  logic [6:0]            w_lower_addr;
  logic [12:0]           w_chunk_min;
  logic [12:0]           w_beats_ceil;
  logic [12:0]           w_rem;
  logic                  w_last_beat;
  logic                  w_accept;
  logic [BeatBytes-1:0]  w_keep_last;
  logic [BeatBytes-1:0]  w_keep;
  t_cpl_hdr              w_hdr_out;
  logic [12:0]           w_req_bytes;

  assign w_req_in = '{
    tag:    req_tag,
    rid:    req_rid,
    tc:     req_tc,
    attr:   req_attr,
    addr:   req_addr,
    len_dw: req_len_dw
  };

  // Progress is tracked as bytes sent; remaining count and address derive from it.
  assign w_total      = (r_req.len_dw == 10'd0) ? 13'd4096 : {1'b0, r_req.len_dw, 2'b00};
  assign w_left       = w_total - r_sent;
  assign w_lower_addr = 7'(r_req.addr + r_sent[11:0]);
  assign w_chunk_min  = (w_left > 13'(MAX_CPL_BYTES)) ? 13'(MAX_CPL_BYTES) : w_left;
  assign w_beats_ceil = (w_chunk_min + 13'(BeatBytes - 1)) >> BeatShift;
  assign w_rem        = r_chunk & 13'(BeatBytes - 1);
  assign w_last_beat  = (r_beats == 13'd1);
  assign w_keep_last  = BeatBytes'(cpl_tkeep(w_rem));
  assign w_keep       = w_last_beat ? w_keep_last : '1;
  assign w_hdr_out    = r_first ? r_hdr : '0;

  assign req_ready = (r_state == StIdle) && !rst;
  assign i_tready  = (r_state == StXfer) && !rst && (!o_tvalid || o_tready);
  assign w_accept  = i_tvalid && i_tready;
  assign busy      = (r_state != StIdle) || o_tvalid;

  always_comb begin
    w_state_d = r_state;
    w_req_d   = r_req;
    w_sent_d  = r_sent;
    w_chunk_d = r_chunk;
    w_beats_d = r_beats;
    w_first_d = r_first;
    w_hdr_d   = r_hdr;
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_req_d   = w_req_in;
          w_sent_d  = '0;
          w_state_d = StChunk;
        end
      end
      StChunk: begin
        w_chunk_d          = w_chunk_min;
        w_beats_d          = w_beats_ceil;
        w_first_d          = 1'b1;
        w_hdr_d            = '0;
        w_hdr_d.fmt_type   = FMT_TYPE_CPLD;
        w_hdr_d.status     = CPL_STATUS_SC;
        w_hdr_d.length     = w_chunk_min[11:2];
        w_hdr_d.byte_count = w_left[11:0];
        w_hdr_d.lower_addr = w_lower_addr;
        w_hdr_d.cpl_id     = cpl_id;
        w_hdr_d.req_id     = r_req.rid;
        w_hdr_d.tag_lo     = r_req.tag[7:0];
        w_hdr_d.tag8       = r_req.tag[8];
        w_hdr_d.tag9       = r_req.tag[9];
        w_hdr_d.tc         = r_req.tc;
        w_hdr_d.attr       = r_req.attr[1:0];
        w_hdr_d.attr2      = r_req.attr[2];
        w_state_d          = StXfer;
      end
      StXfer: begin
        if (w_accept) begin
          w_first_d = 1'b0;
          w_beats_d = r_beats - 13'd1;
          if (w_last_beat) begin
            w_sent_d  = r_sent + r_chunk;
            w_state_d = (w_left == r_chunk) ? StIdle : StChunk;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_req   <= '0;
      r_sent  <= '0;
      r_chunk <= '0;
      r_beats <= '0;
      r_first <= 1'b0;
      r_hdr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_req   <= w_req_d;
      r_sent  <= w_sent_d;
      r_chunk <= w_chunk_d;
      r_beats <= w_beats_d;
      r_first <= w_first_d;
      r_hdr   <= w_hdr_d;
    end
  end

  pcie_ss_axis_cpl_gen_oreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_oreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_data      (i_tdata),
    .i_keep      (w_keep),
    .i_last      (w_last_beat),
    .i_sop       (r_first),
    .i_hdr       (w_hdr_out),
    .o_tready    (o_tready),
    .o_tvalid    (o_tvalid),
    .o_tdata     (o_tdata),
    .o_tkeep     (o_tkeep),
    .o_tlast     (o_tlast),
    .o_tuser_sop (o_tuser_sop),
    .o_tuser_hdr (o_tuser_hdr)
  );

  // Multi-completion reads must start 64-byte aligned so later chunks land on RCB.
  assign w_req_bytes = (req_len_dw == 10'd0) ? 13'd4096 : {1'b0, req_len_dw, 2'b00};

  a_multi_cpl_aligned : assert property (
    @(posedge clk) disable iff (rst)
    (req_valid && req_ready && (w_req_bytes > 13'(MAX_CPL_BYTES))) |-> (req_addr[5:0] == 6'd0)
  );

endmodule
